// File: rtl/note_grid_pkg.sv
// ---------------------------------------------------------------------------
// note_grid_pkg : colours, default grid geometry and FSM encoding for the
//                 three-lane note grid drawer.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package note_grid_pkg;

    localparam logic [2:0] BLACK  = 3'b000;
    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b110;
    localparam logic [2:0] BLUE   = 3'b001;

    localparam int GRID_START_X     = 1;
    localparam int GRID_START_Y     = 53;
    localparam int GRID_PITCH       = 5;
    localparam int GRID_NUM_SQUARES = 30;
    localparam int SQ_SIZE          = 4;
    localparam int NUM_ROWS         = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        FIN  = 2'd2
    } state_t;

    function automatic logic [2:0] lane_colour(input logic [1:0] row);
        case (row)
            2'd0:    lane_colour = RED;
            2'd1:    lane_colour = YELLOW;
            2'd2:    lane_colour = BLUE;
            default: lane_colour = BLACK;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/square_raster.sv
// ---------------------------------------------------------------------------
// square_raster : raster pixel counter for one 4x4 square (x fastest).
//                 Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module square_raster
    import note_grid_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       i_en,
    input  logic       i_clr,
    output logic [1:0] o_dx,
    output logic [1:0] o_dy,
    output logic       o_last
);

    logic [3:0] r_pix;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pix <= 4'd0;
        end else if (i_clr) begin
            r_pix <= 4'd0;
        end else if (i_en) begin
            r_pix <= r_pix + 4'd1;
        end
    end

    assign o_dx   = r_pix[1:0];
    assign o_dy   = r_pix[3:2];
    assign o_last = (r_pix == 4'(SQ_SIZE * SQ_SIZE - 1));

endmodule

`default_nettype wire

// File: rtl/note_grid_draw_ctrl.sv
// ---------------------------------------------------------------------------
// note_grid_draw_ctrl : walks the 3x30 note grid one pixel per clock, painting
//                       snapshotted notes in lane colour and erasing the rest.
//                       Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module note_grid_draw_ctrl
    import note_grid_pkg::*;
#(
    parameter int START_X     = GRID_START_X,
    parameter int START_Y     = GRID_START_Y,
    parameter int PITCH       = GRID_PITCH,
    parameter int NUM_SQUARES = GRID_NUM_SQUARES
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   start,
    input  logic                   clear,
    input  logic [NUM_SQUARES-1:0] red_sequence,
    input  logic [NUM_SQUARES-1:0] yellow_sequence,
    input  logic [NUM_SQUARES-1:0] blue_sequence,
    output logic                   busy,
    output logic                   done,
    output logic [7:0]             vga_x,
    output logic [6:0]             vga_y,
    output logic [2:0]             vga_colour,
    output logic                   vga_plot
);

    localparam int SQ_W = $clog2(NUM_SQUARES);

    state_t                 r_state;
    logic [NUM_SQUARES-1:0] r_red;
    logic [NUM_SQUARES-1:0] r_yellow;
    logic [NUM_SQUARES-1:0] r_blue;
    logic                   r_clear;
    logic [SQ_W-1:0]        r_sq;
    logic [1:0]             r_row;
    logic [7:0]             r_base_x;
    logic [6:0]             r_base_y;

    logic [1:0]             w_dx;
    logic [1:0]             w_dy;
    logic                   w_last_pix;
    logic                   w_last_sq;
    logic                   w_last_row;
    logic [NUM_SQUARES-1:0] w_lane_seq;
    logic                   w_note;

    // Pixel counter is held at zero whenever we are not drawing.
    square_raster u_raster (
        .clk    (clk),
        .resetn (resetn),
        .i_en   (r_state == DRAW),
        .i_clr  (r_state != DRAW),
        .o_dx   (w_dx),
        .o_dy   (w_dy),
        .o_last (w_last_pix)
    );

    assign w_last_sq  = (r_sq == SQ_W'(NUM_SQUARES - 1));
    assign w_last_row = (r_row == 2'(NUM_ROWS - 1));
    assign w_lane_seq = (r_row == 2'd0) ? r_red :
                        (r_row == 2'd1) ? r_yellow : r_blue;
    assign w_note     = w_lane_seq[r_sq] & ~r_clear;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_red      <= '0;
            r_yellow   <= '0;
            r_blue     <= '0;
            r_clear    <= 1'b0;
            r_sq       <= '0;
            r_row      <= 2'd0;
            r_base_x   <= 8'd0;
            r_base_y   <= 7'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            vga_x      <= 8'd0;
            vga_y      <= 7'd0;
            vga_colour <= BLACK;
            vga_plot   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    vga_plot <= 1'b0;
                    if (start) begin
                        r_red    <= red_sequence;
                        r_yellow <= yellow_sequence;
                        r_blue   <= blue_sequence;
                        r_clear  <= clear;
                        r_sq     <= '0;
                        r_row    <= 2'd0;
                        r_base_x <= 8'(START_X);
                        r_base_y <= 7'(START_Y);
                        busy     <= 1'b1;
                        r_state  <= DRAW;
                    end
                end
                DRAW: begin
                    vga_plot   <= 1'b1;
                    vga_x      <= r_base_x + {6'd0, w_dx};
                    vga_y      <= r_base_y + {5'd0, w_dy};
                    vga_colour <= w_note ? lane_colour(r_row) : BLACK;
                    if (w_last_pix) begin
                        if (w_last_sq) begin
                            r_sq     <= '0;
                            r_base_x <= 8'(START_X);
                            if (w_last_row) begin
                                r_state <= FIN;
                            end else begin
                                r_row    <= r_row + 2'd1;
                                r_base_y <= r_base_y + 7'(PITCH);
                            end
                        end else begin
                            r_sq     <= r_sq + SQ_W'(1);
                            r_base_x <= r_base_x + 8'(PITCH);
                        end
                    end
                end
                FIN: begin
                    vga_plot <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    r_state  <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/note_grid_draw_ctrl.md
Name: note_grid_draw_ctrl

Overview:
- Sequences the VGA plotter through the three-lane note grid: 3 rows (red, yellow, blue) of 30 squares, each 4x4 pixels, drawn one pixel per clock.
- On a frame-start pulse it snapshots the three 30-bit note sequences. It then walks every square, painting it in the lane colour where a note is present and in black (erase) where none is.
- Sits between the note shifters and the vga_adapter plot port. Its `done` output tells the game FSM when it may shift the sequences again.

Parameters:
- START_X, 1, x of the left edge of square 0
- START_Y, 53, y of the top edge of row 0 (red)
- PITCH, 5, pixel distance between adjacent square origins, in both x and y
- NUM_SQUARES, 30, squares per row; sequence bit i maps to square i

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  frame-draw request; sampled only in IDLE
- clear  in  1  sampled with start; 1 = erase the whole grid regardless of sequences
- red_sequence  in  30  lane 0 notes; bit i = 1 means a note in square i
- yellow_sequence  in  30  lane 1 notes
- blue_sequence  in  30  lane 2 notes
- busy  out  1  high from the cycle after start is accepted through the last plot cycle
- done  out  1  one-cycle pulse after the final pixel
- vga_x  out  8  pixel x coordinate
- vga_y  out  7  pixel y coordinate
- vga_colour  out  3  RGB colour, 3 bits
- vga_plot  out  1  write enable to the plotter

Behaviour:
- All outputs are registered.
- Reset state: state = IDLE; busy, done, vga_plot, vga_x, vga_y and vga_colour are all 0. Reset is asynchronous and takes effect immediately, including mid-frame; the partial frame is abandoned with no done pulse.
- States:
  - IDLE: waits for start.
  - DRAW: emits one pixel per cycle.
  - FIN: one cycle, done = 1.
  - FIN returns to IDLE unconditionally.
- IDLE -> DRAW: when start = 1, latch the three sequences and clear into snapshot registers. Reset counters: pix = 0, sq = 0, row = 0. Set base_x = START_X and base_y = START_Y.
- DRAW, each cycle:
  - vga_plot = 1
  - vga_x = base_x + pix[1:0]
  - vga_y = base_y + pix[3:2]
  - colour = lane colour (row 0 RED 100, row 1 YELLOW 110, row 2 BLUE 001) if the snapshot bit[sq] of that row is 1 and clear is 0; otherwise BLACK 000.
- Counter advance:
  - pix increments 0..15.
  - On pix = 15: pix wraps to 0, sq increments, base_x += PITCH.
  - On sq = NUM_SQUARES-1 with pix = 15: sq = 0, base_x = START_X, row increments, base_y += PITCH.
  - On row = 2, sq = 29, pix = 15: next state is FIN.
- No multipliers: base coordinates are accumulated with adders.
- Widths: x maximum is 1 + 5·29 + 3 = 149 (< 160); y maximum is 53 + 10 + 3 = 66 (< 120). No wrap is possible with the defaults.
- Timing: start is accepted at edge 0. The first plot is visible after edge 1. There are exactly 1440 plot cycles (3·30·16), and done is high for the single cycle after the last plot.
- busy = 1 throughout DRAW and 0 in FIN and IDLE.
- vga_plot = 0 in IDLE and FIN, with coordinates and colour holding their last values.
- start while busy or in FIN: ignored, not queued.
- start and clear held high continuously: a new frame begins on the cycle after FIN (from IDLE).
- Sequence inputs changing mid-frame have no effect, because the snapshot is used.
- Row order is red, yellow, blue; square order is left to right; pixel order within a square is raster (x fastest).

Decomposition:
- Package note_grid_pkg:
  - colour localparams BLACK, RED, YELLOW, BLUE
  - default geometry constants: START_X, START_Y, PITCH, SQ_SIZE = 4, NUM_ROWS = 3
  - state encoding: IDLE, DRAW, FIN
- Sub-module square_raster: a 4-bit pixel counter with enable/clear that outputs the dx/dy offsets and a last_pixel flag. The top level owns the square/row counters, base accumulators, snapshot and FSM.

Test Plan:
- Reset, then start pulse with red bit0 = 1, others 0 → first plot at (1,53) colour 100; pixel 15 at (4,56); square 1 pixel 0 at (6,53) colour 000.
- Full frame, all sequences = 30'h3FFFFFFF → exactly 1440 plot cycles; last pixel (149,66) colour 001; done pulses once, 1441 cycles after start.
- yellow = 30'h20000000 (bit29) → only pixels x 146..149, y 58..61 have colour 110; all other yellow-row pixels are 000.
- clear = 1 with all sequences set → all 1440 pixels have colour 000.
- Second start mid-frame and sequences toggled mid-frame → frame length is still 1440, and colours match the values snapshotted at the first start.
- resetn low at plot cycle 700 → all outputs go to 0 asynchronously and there is no done pulse; a subsequent start draws a full frame from (1,53).
